// File: rtl/sy_uart_pkg.sv
// Shared types and constants for the console UART transmit path.
package sy_uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_DIV_W     = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sy_uart_tx_if.sv
// Byte-write handshake between the MMIO decoder and the UART transmit stage.
interface sy_uart_tx_if;
    import sy_uart_pkg::*;

    logic                      wr_valid_i;
    logic [UART_DATA_BITS-1:0] wr_data_i;
    logic                      wr_ready_o;

    modport master (output wr_valid_i, output wr_data_i, input  wr_ready_o);
    modport slave  (input  wr_valid_i, input  wr_data_i, output wr_ready_o);

endinterface

// File: rtl/sy_sync_fifo.sv
// Single-clock FIFO with occupancy count; power-of-two depth, no empty bypass.
module sy_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == FULL_CNT);
    assign o_empty   = (r_cnt == {(AW+1){1'b0}});
    assign o_cnt     = r_cnt;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_cnt    <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/sy_uart_tx.sv
// Console UART transmitter: byte FIFO, latched baud divider and frame FSM.
module sy_uart_tx
    import sy_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    sy_uart_tx_if.slave                   wr_if,
    input  logic [UART_DIV_W-1:0]         baud_div_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
    output logic                          tx_done_o
);

    localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_START  = 3'(START);
    localparam logic [2:0] S_DATA   = 3'(DATA);
    localparam logic [2:0] S_PARITY = 3'(PARITY);
    localparam logic [2:0] S_STOP   = 3'(STOP);

    logic [2:0]                r_state;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_parity;
    logic [UART_DIV_W-1:0]     r_div;
    logic [UART_DIV_W-1:0]     r_bit_cnt;
    logic [2:0]                r_bit_idx;
    logic                      r_stop_idx;
    logic                      r_tx;
    logic                      r_tx_done;
    logic                      r_busy;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic [UART_DATA_BITS-1:0] w_rdata;
    logic [CNT_W-1:0]          w_cnt;
    logic                      w_bit_end;
    logic                      w_last_stop;
    logic [UART_DIV_W-1:0]     w_div_lat;

    assign w_push           = wr_if.wr_valid_i && !w_full;
    assign wr_if.wr_ready_o = !w_full;
    assign w_div_lat        = (baud_div_i == 16'd0) ? 16'd1 : baud_div_i;
    assign w_bit_end        = (r_bit_cnt == (r_div - 16'd1));
    assign w_last_stop      = (r_stop_idx == 1'(STOP_BITS - 1));

    assign tx_o       = r_tx;
    assign tx_done_o  = r_tx_done;
    assign busy_o     = r_busy;
    assign fifo_cnt_o = w_cnt;

    sy_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (wr_if.wr_data_i),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_cnt   (w_cnt)
    );

    // Pop when a new frame is loaded: from IDLE, or straight out of the last stop bit.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = !w_empty;
            S_STOP:  w_pop = w_bit_end && w_last_stop && !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    // Frame sequencer; tx is registered here so the line never glitches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_shift    <= {UART_DATA_BITS{1'b0}};
            r_parity   <= 1'b0;
            r_div      <= 16'd1;
            r_bit_cnt  <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= w_rdata;
                        r_parity  <= even_parity(w_rdata);
                        r_div     <= w_div_lat;
                        r_bit_cnt <= 16'd0;
                        r_tx      <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= 16'd0;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= 16'd0;
                        if (r_bit_idx == 3'd7) begin
                            r_stop_idx <= 1'b0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_bit_cnt  <= 16'd0;
                        r_stop_idx <= 1'b0;
                        r_tx       <= 1'b1;
                        r_state    <= S_STOP;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= 16'd0;
                        if (w_last_stop) begin
                            r_tx_done <= 1'b1;
                            if (w_pop) begin
                                r_shift  <= w_rdata;
                                r_parity <= even_parity(w_rdata);
                                r_div    <= w_div_lat;
                                r_tx     <= 1'b0;
                                r_state  <= S_START;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Busy lags the FSM by one cycle so it stays high through the final done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE) || (w_cnt != {CNT_W{1'b0}}) || w_push;
        end
    end

endmodule

// File: tb/tb_sy_uart_tx.sv
// Directed bench for sy_uart_tx: frame vectors, burst/backpressure, reset abort, baud change.
module tb_sy_uart_tx;
    import sy_uart_pkg::*;

    typedef struct {
        logic        sel;
        logic [15:0] div;
        logic [7:0]  data;
        logic [11:0] pat;
        int          nbits;
        int          len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud0, baud1;
    logic        tx0, busy0, done0, tx1, busy1, done1;
    logic [4:0]  cnt0, cnt1;
    logic        cap_tx   [0:511];
    logic        cap_done [0:511];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    sy_uart_tx_if if0 ();
    sy_uart_tx_if if1 ();

    sy_uart_tx #(.FIFO_DEPTH(16), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .wr_if(if0), .baud_div_i(baud0),
        .tx_o(tx0), .busy_o(busy0), .fifo_cnt_o(cnt0), .tx_done_o(done0));

    sy_uart_tx #(.FIFO_DEPTH(16), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .wr_if(if1), .baud_div_i(baud1),
        .tx_o(tx1), .busy_o(busy1), .fifo_cnt_o(cnt1), .tx_done_o(done1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic get_tx(input logic sel);    return sel ? tx1 : tx0;     endfunction
    function automatic logic get_busy(input logic sel);  return sel ? busy1 : busy0; endfunction
    function automatic logic get_done(input logic sel);  return sel ? done1 : done0; endfunction
    function automatic logic [4:0] get_cnt(input logic sel); return sel ? cnt1 : cnt0; endfunction
    function automatic logic get_ready(input logic sel);
        return sel ? if1.wr_ready_o : if0.wr_ready_o;
    endfunction

    // Reference 8-N-1 line level for bit slot b (0 = start, 1..8 = data, 9 = stop).
    function automatic logic lvl(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        else if (b <= 8) return d[b-1];
        else return 1'b1;
    endfunction

    task automatic drive(input logic sel, input logic v, input logic [7:0] d);
        if (sel) begin if1.wr_valid_i = v; if1.wr_data_i = d; end
        else     begin if0.wr_valid_i = v; if0.wr_data_i = d; end
    endtask

    task automatic wr_byte(input logic sel, input logic [7:0] d, output int stalls);
        stalls = 0;
        drive(sel, 1'b1, d);
        while (!get_ready(sel) && stalls < 200) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 200) chk("wr_byte_timeout", 32'(stalls), 32'd0);
        @(negedge clk);
        drive(sel, 1'b0, 8'h00);
    endtask

    task automatic capture(input logic sel, input int n);
        int w = 0;
        while (get_tx(sel) !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("capture_start_timeout", 32'(w), 32'd0);
        for (int j = 0; j < n; j++) begin
            cap_tx[j]   = get_tx(sel);
            cap_done[j] = get_done(sel);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input logic sel, input string nm);
        int w = 0;
        while (get_busy(sel) !== 1'b0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk(nm, 32'(get_busy(sel)), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int st;
        int cpb;
        int mism = 0;
        int early = 0;
        cpb = v.len / v.nbits;
        if (v.sel) baud1 = v.div; else baud0 = v.div;
        wr_byte(v.sel, v.data, st);
        chk($sformatf("v%0d_tx_before_start", id), 32'(get_tx(v.sel)), 32'd1);
        chk($sformatf("v%0d_busy_after_write", id), 32'(get_busy(v.sel)), 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d_first_low", id), 32'(get_tx(v.sel)), 32'd0);
        for (int j = 0; j < v.len; j++) begin
            if (get_tx(v.sel) !== v.pat[j / cpb]) mism++;
            if (get_done(v.sel) !== 1'b0) early++;
            @(negedge clk);
        end
        chk($sformatf("v%0d_line_mismatches", id), 32'(mism), 32'd0);
        chk($sformatf("v%0d_early_done", id), 32'(early), 32'd0);
        chk($sformatf("v%0d_done_pulse", id), 32'(get_done(v.sel)), 32'd1);
        chk($sformatf("v%0d_busy_at_done", id), 32'(get_busy(v.sel)), 32'd1);
        chk($sformatf("v%0d_tx_idle", id), 32'(get_tx(v.sel)), 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d_done_cleared", id), 32'(get_done(v.sel)), 32'd0);
        chk($sformatf("v%0d_busy_dropped", id), 32'(get_busy(v.sel)), 32'd0);
        chk($sformatf("v%0d_fifo_empty", id), 32'(get_cnt(v.sel)), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        vec_t v55;
        int   st;
        int   mism;
        int   ndone;
        logic [7:0] d;

        vecs[0] = '{1'b0, 16'd4, 8'hA5, 12'h34A, 10, 40};
        vecs[1] = '{1'b0, 16'd0, 8'hFF, 12'h3FE, 10, 10};
        vecs[2] = '{1'b0, 16'd1, 8'hFF, 12'h3FE, 10, 10};
        vecs[3] = '{1'b0, 16'd3, 8'h3C, 12'h278, 10, 30};
        vecs[4] = '{1'b0, 16'd5, 8'h80, 12'h300, 10, 50};
        vecs[5] = '{1'b1, 16'd3, 8'h07, 12'hE0E, 12, 36};
        vecs[6] = '{1'b1, 16'd2, 8'h03, 12'hC06, 12, 24};
        v55     = '{1'b0, 16'd4, 8'h55, 12'h2AA, 10, 40};

        rst = 1'b1;
        baud0 = 16'd4;
        baud1 = 16'd4;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx0), 32'd1);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_ready", 32'(if0.wr_ready_o), 32'd1);
        chk("rst_tx_par", 32'(tx1), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Burst of 18 bytes at div=2: 16 fill, 17th fills the FIFO, 18th stalls.
        baud0 = 16'd2;
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    chk($sformatf("burst_ready_%0d", k), 32'(if0.wr_ready_o), 32'd1);
                    drive(1'b0, 1'b1, 8'(k));
                    @(negedge clk);
                end
                chk("burst_cnt_peak", 32'(cnt0), 32'd15);
                chk("burst_ready_16", 32'(if0.wr_ready_o), 32'd1);
                drive(1'b0, 1'b1, 8'h10);
                @(negedge clk);
                chk("burst_full_ready", 32'(if0.wr_ready_o), 32'd0);
                chk("burst_full_cnt", 32'(cnt0), 32'd16);
                wr_byte(1'b0, 8'h11, st);
                chk("burst_stall_cycles", 32'(st), 32'd5);
            end
            begin
                capture(1'b0, 361);
            end
        join
        ndone = 0;
        for (int f = 0; f < 18; f++) begin
            d = (f < 16) ? 8'(f) : ((f == 16) ? 8'h10 : 8'h11);
            mism = 0;
            for (int s = 0; s < 20; s++) begin
                if (cap_tx[f*20 + s] !== lvl(d, s / 2)) mism++;
            end
            chk($sformatf("burst_frame_%0d", f), 32'(mism), 32'd0);
        end
        for (int s = 0; s < 361; s++) if (cap_done[s] === 1'b1) ndone++;
        chk("burst_done_count", 32'(ndone), 32'd18);
        chk("burst_done_last", 32'(cap_done[360]), 32'd1);
        wait_idle(1'b0, "burst_idle");
        chk("burst_cnt_final", 32'(cnt0), 32'd0);

        // Divider change mid-frame applies only to the following frame.
        baud0 = 16'd4;
        @(negedge clk);
        fork
            begin
                wr_byte(1'b0, 8'h5A, st);
                wr_byte(1'b0, 8'hC3, st);
                repeat (12) @(negedge clk);
                baud0 = 16'd8;
            end
            begin
                capture(1'b0, 121);
            end
        join
        mism = 0;
        for (int s = 0; s < 40; s++)  if (cap_tx[s] !== lvl(8'h5A, s / 4)) mism++;
        chk("baud_frame_div4", 32'(mism), 32'd0);
        mism = 0;
        for (int s = 0; s < 80; s++)  if (cap_tx[40 + s] !== lvl(8'hC3, s / 8)) mism++;
        chk("baud_frame_div8", 32'(mism), 32'd0);
        chk("baud_done_first", 32'(cap_done[40]), 32'd1);
        chk("baud_done_second", 32'(cap_done[120]), 32'd1);
        wait_idle(1'b0, "baud_idle");

        // Asynchronous reset mid-DATA with five bytes still queued.
        baud0 = 16'd4;
        wr_byte(1'b0, 8'h00, st);
        wr_byte(1'b0, 8'h11, st);
        wr_byte(1'b0, 8'h22, st);
        wr_byte(1'b0, 8'h33, st);
        wr_byte(1'b0, 8'h44, st);
        wr_byte(1'b0, 8'h55, st);
        chk("arst_queued", 32'(cnt0), 32'd5);
        repeat (8) @(negedge clk);
        chk("arst_pre_tx_low", 32'(tx0), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tx", 32'(tx0), 32'd1);
        chk("arst_cnt", 32'(cnt0), 32'd0);
        chk("arst_busy", 32'(busy0), 32'd0);
        chk("arst_ready", 32'(if0.wr_ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(v55, 7);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sy_uart_tx.md
Name: sy_uart_tx

Overview:
Console transmit stage that consumes byte writes from the SoC's MMIO UART data register and serialises them onto a single-wire 8-N-1 (configurable) UART line. Used by the Linux boot simulation and the FPGA build as the downstream console sink.
The block contains a small byte FIFO that decouples core store bursts from the slow serial line, a baud-rate divider, and a transmit frame state machine.

Parameters:
FIFO_DEPTH, 16, byte FIFO entries; power of two, minimum 2.
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk_i  in  1  core clock.
rst_i  in  1  asynchronous active-high reset.
wr_valid_i  in  1  byte write request from the MMIO decoder.
wr_data_i  in  8  byte to transmit.
wr_ready_o  out  1  FIFO can accept; equals !full.
baud_div_i  in  16  clock cycles per serial bit; quasi-static.
tx_o  out  1  serial line; idles high.
busy_o  out  1  high when the FIFO is non-empty or a frame is in flight.
fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
tx_done_o  out  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (asynchronous, active-high):
  - tx_o=1, busy_o=0, fifo_cnt_o=0, tx_done_o=0, wr_ready_o=1.
  - FSM=IDLE; all counters cleared.
  - Reset mid-frame aborts the frame: tx_o returns to 1 immediately and FIFO contents are discarded.
- Write handshake:
  - A byte is accepted on a rising edge with wr_valid_i && wr_ready_o.
  - Writes while full are not accepted and are not dropped silently: the source holds wr_valid_i.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - The full condition is evaluated before the pop, so a write in the same cycle as a pop from a full FIFO is rejected.
  - Pointers wrap modulo FIFO_DEPTH.
  - There is no empty bypass.
- Baud divider:
  - The divider value is latched from baud_div_i when the FSM leaves IDLE; a value of 0 is treated as 1.
  - A bit counter counts 0..div-1; the bit advances when the count reaches div-1.
  - Changes to baud_div_i mid-frame take effect on the next frame.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
  - IDLE: if the FIFO is non-empty, pop one byte into the shift register and go to START. tx_o=1.
  - START: tx_o=0 for div cycles.
  - DATA: send 8 bits LSB first, div cycles each; a 3-bit index counts the bits.
  - PARITY (only when PARITY_EN=1): tx_o = XOR of the 8 data bits, for div cycles.
  - STOP: tx_o=1 for STOP_BITS*div cycles.
  - At the end of STOP: pulse tx_done_o. If the FIFO is non-empty, pop and go directly to START (back-to-back frames with no idle gap); otherwise go to IDLE.
- tx_o is driven from a flop (glitch-free).
- Latency: a byte accepted in cycle N into an empty, idle block is popped in cycle N+1, and tx_o falls at the start of cycle N+2.
- Frame length: (10 + PARITY_EN + STOP_BITS - 1) * div cycles.
- busy_o = (FSM != IDLE) || (fifo_cnt_o != 0), registered-equivalent. It drops in the cycle after the final tx_done_o when the FIFO is empty.

Decomposition:
- Shared package sy_uart_pkg:
  - enum uart_tx_state_e {IDLE, START, DATA, PARITY, STOP}.
  - localparams UART_DATA_BITS=8 and UART_DIV_W=16.
- Sub-module sy_sync_fifo (parameterised WIDTH, DEPTH):
  - Ports: push, pop, wdata, rdata, full, empty, cnt.
  - Reusable elsewhere in the SoC.
- The top level holds the divider, FSM and shift register.

Test Plan:
- div=4, write 0xA5 once.
  - tx_o: low for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles.
  - tx_done_o pulses once, 40 cycles after the first low.
  - busy_o is 0 afterwards.
- div=2, write 16 bytes 0x00..0x0F back-to-back.
  - All 16 are accepted with no stall; fifo_cnt_o peaks at 15 or 16.
  - Burst 17: wr_ready_o=0 until the first pop.
  - The line carries 16 contiguous 20-cycle frames with no idle gap.
- div=0, write 0xFF.
  - Behaves identically to div=1: the frame is 10 cycles and tx_o is low only during the start bit.
- PARITY_EN=1, STOP_BITS=2, div=3, write 0x07.
  - Parity bit = 1; stop high for 6 cycles; frame is 36 cycles.
- Assert rst_i asynchronously mid-DATA, with 5 bytes queued.
  - tx_o=1 within the same time step.
  - fifo_cnt_o=0 and busy_o=0.
  - After release, a new write of 0x55 transmits correctly.
- Change baud_div_i from 4 to 8 mid-frame.
  - The current frame completes at 4 cycles per bit; the next frame uses 8.
